issue_steer_queue: RTL and testbench

Dual-issue steering stage with an internal instruction queue, placed between fetch and the two execution pipes. Fetch pushes up to two instructions per cycle. Each cycle the block pops up to two oldest instructions, in order, and routes them to pipe 0 (branch-capable) and pipe 1 (memory-capable). The output is registered. A structural conflict issues the head instruction alone; it does not stall fetch, because the queue absorbs the difference.

---
 rtl/issue_steer_queue.sv | 206 ++++++++++++++++++++
 tb/tb_issue_steer_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/issue_steer_queue.sv
// Dual-issue steering stage: a circular instruction queue fed by fetch (up to two per
// cycle) that issues up to two oldest instructions per cycle to a branch pipe and a memory pipe.
module issue_steer_queue #(
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int OPCODE_MSB = 31,
  parameter int OPCODE_LSB = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [1:0]              in_valid,
  input  logic [INST_WIDTH-1:0]   in_inst0,
  input  logic [INST_WIDTH-1:0]   in_inst1,
  output logic                    in_ready,
  output logic                    out_valid0,
  output logic                    out_valid1,
  output logic [INST_WIDTH-1:0]   out_inst0,
  output logic [INST_WIDTH-1:0]   out_inst1,
  output logic                    out_first,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OP_W  = OPCODE_MSB - OPCODE_LSB + 1;

  // Compare/test opcodes that live outside the 11xxxx branch group but still need pipe 0
  localparam logic [OP_W-1:0] OP_CODE_CMP   = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_CODE_TEST  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_CODE_CMPI  = OP_W'(6'b001110);
  localparam logic [OP_W-1:0] OP_CODE_TESTI = OP_W'(6'b001111);

  typedef enum logic [1:0] {
    CLS_ANY    = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_MEMORY = 2'd2
  } cls_e;

  function automatic cls_e classify(input logic [OP_W-1:0] op);
    cls_e cls;
    cls = CLS_ANY;
    if (op[OP_W-1:OP_W-2] == 2'b11 || op == OP_CODE_CMP || op == OP_CODE_TEST ||
        op == OP_CODE_CMPI || op == OP_CODE_TESTI)
      cls = CLS_BRANCH;
    else if (op[OP_W-1:OP_W-2] == 2'b10)
      cls = CLS_MEMORY;
    return cls;
  endfunction

  logic [INST_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  out_valid0_q, out_valid0_d;
  logic                  out_valid1_q, out_valid1_d;
  logic [INST_WIDTH-1:0] out_inst0_q, out_inst0_d;
  logic [INST_WIDTH-1:0] out_inst1_q, out_inst1_d;
  logic                  out_first_q, out_first_d;

  logic [PTR_W-1:0]      head_p1, tail_p1;
  logic                  push_en, wr0, wr1, load;
  logic [1:0]            push_n, pop_eff, push_eff;
  logic [INST_WIDTH-1:0] h_inst, n_inst;
  cls_e                  h_cls, n_cls;
  logic                  have_h, have_n;

  logic                  st_v0, st_v1, st_first;
  logic [INST_WIDTH-1:0] st_i0, st_i1;
  logic [1:0]            st_pop;

  // Free-entry check uses the registered count only, so a same-cycle pop never helps
  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  always_comb begin
    push_en = in_ready && (in_valid != 2'b00);
    wr0     = push_en && in_valid[0] && !flush;
    wr1     = push_en && in_valid[0] && in_valid[1] && !flush;
    push_n  = {1'b0, wr0} + {1'b0, wr1};
    load    = out_ready || !(out_valid0_q || out_valid1_q);
  end

  always_ff @(posedge clk) begin
    if (wr0) mem_q[tail_q]  <= in_inst0;
    if (wr1) mem_q[tail_p1] <= in_inst1;
  end

  // Steering: decide routing for the head (and next) entry
  always_comb begin
    h_inst   = mem_q[head_q];
    n_inst   = mem_q[head_p1];
    h_cls    = classify(h_inst[OPCODE_MSB:OPCODE_LSB]);
    n_cls    = classify(n_inst[OPCODE_MSB:OPCODE_LSB]);
    have_h   = (count_q >= CNT_W'(1));
    have_n   = (count_q >= CNT_W'(2));
    st_v0    = 1'b0;
    st_v1    = 1'b0;
    st_i0    = out_inst0_q;
    st_i1    = out_inst1_q;
    st_first = 1'b0;
    st_pop   = 2'd0;
    if (have_h && !have_n) begin
      st_pop = 2'd1;
      if (h_cls == CLS_MEMORY) begin
        st_v1    = 1'b1;
        st_i1    = h_inst;
        st_first = 1'b1;
      end else begin
        st_v0 = 1'b1;
        st_i0 = h_inst;
      end
    end else if (have_n) begin
      if (h_cls == CLS_BRANCH && n_cls == CLS_BRANCH) begin
        st_v0  = 1'b1;
        st_i0  = h_inst;
        st_pop = 2'd1;
      end else if (h_cls == CLS_MEMORY && n_cls == CLS_MEMORY) begin
        st_v1    = 1'b1;
        st_i1    = h_inst;
        st_first = 1'b1;
        st_pop   = 2'd1;
      end else if (h_cls == CLS_MEMORY || (h_cls == CLS_ANY && n_cls == CLS_BRANCH)) begin
        st_v0    = 1'b1;
        st_v1    = 1'b1;
        st_i0    = n_inst;
        st_i1    = h_inst;
        st_first = 1'b1;
        st_pop   = 2'd2;
      end else begin
        st_v0  = 1'b1;
        st_v1  = 1'b1;
        st_i0  = h_inst;
        st_i1  = n_inst;
        st_pop = 2'd2;
      end
    end
  end

  // Next-state: flush overrides both push and pop
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    out_valid0_d = out_valid0_q;
    out_valid1_d = out_valid1_q;
    out_inst0_d  = out_inst0_q;
    out_inst1_d  = out_inst1_q;
    out_first_d  = out_first_q;
    push_eff     = push_n;
    pop_eff      = load ? st_pop : 2'd0;
    if (flush) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      out_valid0_d = 1'b0;
      out_valid1_d = 1'b0;
      out_first_d  = 1'b0;
    end else begin
      tail_d  = tail_q + PTR_W'(push_eff);
      head_d  = head_q + PTR_W'(pop_eff);
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
      if (load) begin
        out_valid0_d = st_v0;
        out_valid1_d = st_v1;
        out_inst0_d  = st_i0;
        out_inst1_d  = st_i1;
        out_first_d  = st_first;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      out_valid0_q <= 1'b0;
      out_valid1_q <= 1'b0;
      out_inst0_q  <= '0;
      out_inst1_q  <= '0;
      out_first_q  <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      out_valid0_q <= out_valid0_d;
      out_valid1_q <= out_valid1_d;
      out_inst0_q  <= out_inst0_d;
      out_inst1_q  <= out_inst1_d;
      out_first_q  <= out_first_d;
    end
  end

  assign out_valid0 = out_valid0_q;
  assign out_valid1 = out_valid1_q;
  assign out_inst0  = out_inst0_q;
  assign out_inst1  = out_inst1_q;
  assign out_first  = out_first_q;
  assign count      = count_q;

endmodule

// File: tb/tb_issue_steer_queue.sv
// Directed bench for issue_steer_queue: pairing/swap rules, lone issue, full queue with
// pointer wrap, flush and asynchronous reset.
module tb_issue_steer_queue;
  localparam int IW    = 32;
  localparam int DEPTH = 8;

  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_CMP   = 6'b001100;
  localparam logic [5:0] OP_TESTI = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_JMP   = 6'b110000;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_JE    = 6'b110101;

  logic          clk = 1'b0;
  logic          reset, flush, out_ready;
  logic [1:0]    in_valid;
  logic [IW-1:0] in_inst0, in_inst1;
  logic          in_ready, out_valid0, out_valid1, out_first;
  logic [IW-1:0] out_inst0, out_inst1;
  logic [3:0]    count;

  int checks   = 0;
  int failures = 0;

  issue_steer_queue #(.INST_WIDTH(IW), .DEPTH(DEPTH), .OPCODE_MSB(31), .OPCODE_LSB(26)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_ready(in_ready),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_inst0(out_inst0), .out_inst1(out_inst1), .out_first(out_first),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(input logic [5:0] op, input int id);
    return {op, 26'(id)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [IW-1:0] a, input logic [IW-1:0] b);
    in_valid = 2'b11;
    in_inst0 = a;
    in_inst1 = b;
    step();
    in_valid = 2'b00;
  endtask

  task automatic push1(input logic [IW-1:0] a);
    in_valid = 2'b01;
    in_inst0 = a;
    step();
    in_valid = 2'b00;
  endtask

  task automatic chk_out(input string tag, input logic v0, input logic v1,
                         input logic [IW-1:0] i0, input logic [IW-1:0] i1, input logic f);
    check({tag, ".v0"}, 64'(out_valid0), 64'(v0));
    check({tag, ".v1"}, 64'(out_valid1), 64'(v1));
    if (v0) check({tag, ".i0"}, 64'(out_inst0), 64'(i0));
    if (v1) check({tag, ".i1"}, 64'(out_inst1), 64'(i1));
    check({tag, ".first"}, 64'(out_first), 64'(f));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 2'b00; in_inst0 = '0; in_inst1 = '0;
    step(); step();
    chk_out("reset", 1'b0, 1'b0, '0, '0, 1'b0);
    check("reset.inst0", 64'(out_inst0), 64'd0);
    check("reset.inst1", 64'(out_inst1), 64'd0);
    check("reset.count", 64'(count), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    step();

    push2(mk(OP_ADD, 1), mk(OP_SUB, 2));
    check("nobypass.v", 64'({out_valid0, out_valid1}), 64'd0);
    check("nobypass.count", 64'(count), 64'd2);
    step();
    chk_out("pair", 1'b1, 1'b1, mk(OP_ADD, 1), mk(OP_SUB, 2), 1'b0);
    check("pair.count", 64'(count), 64'd0);
    step();
    check("empty_load.v", 64'({out_valid0, out_valid1}), 64'd0);

    push2(mk(OP_LW, 3), mk(OP_JMP, 4));
    step();
    chk_out("mem_br", 1'b1, 1'b1, mk(OP_JMP, 4), mk(OP_LW, 3), 1'b1);
    step();
    push2(mk(OP_ADD, 5), mk(OP_TESTI, 6));
    step();
    chk_out("any_br", 1'b1, 1'b1, mk(OP_TESTI, 6), mk(OP_ADD, 5), 1'b1);
    step();

    push2(mk(OP_LW, 7), mk(OP_SW, 8));
    push2(mk(OP_ADD, 9), mk(OP_BEQ, 10));
    chk_out("seq1", 1'b0, 1'b1, '0, mk(OP_LW, 7), 1'b1);
    check("seq1.count", 64'(count), 64'd3);
    step();
    chk_out("seq2", 1'b1, 1'b1, mk(OP_ADD, 9), mk(OP_SW, 8), 1'b1);
    step();
    chk_out("seq3", 1'b1, 1'b0, mk(OP_BEQ, 10), '0, 1'b0);
    check("seq3.count", 64'(count), 64'd0);
    step();

    push2(mk(OP_CMP, 11), mk(OP_JE, 12));
    step();
    chk_out("brbr1", 1'b1, 1'b0, mk(OP_CMP, 11), '0, 1'b0);
    step();
    chk_out("brbr2", 1'b1, 1'b0, mk(OP_JE, 12), '0, 1'b0);
    step();

    push1(mk(OP_LW, 13));
    step();
    chk_out("lone_mem", 1'b0, 1'b1, '0, mk(OP_LW, 13), 1'b1);
    step();

    // Head and tail now sit at 5, so the second pair straddles slots 7/0
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        check("fill.count6", 64'(count), 64'd6);
        check("fill.ready6", 64'(in_ready), 64'd1);
      end
      push2(mk(OP_ADD, 32 + 2 * k), mk(OP_ADD, 33 + 2 * k));
    end
    check("full.count", 64'(count), 64'd8);
    check("full.in_ready", 64'(in_ready), 64'd0);
    chk_out("hold", 1'b1, 1'b1, mk(OP_ADD, 32), mk(OP_ADD, 33), 1'b0);
    step();
    chk_out("hold2", 1'b1, 1'b1, mk(OP_ADD, 32), mk(OP_ADD, 33), 1'b0);

    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out($sformatf("drain%0d", k), 1'b1, 1'b1,
              mk(OP_ADD, 34 + 2 * k), mk(OP_ADD, 35 + 2 * k), 1'b0);
      check($sformatf("drain%0d.count", k), 64'(count), 64'(6 - 2 * k));
    end

    out_ready = 1'b0;
    push2(mk(OP_SUB, 50), mk(OP_SUB, 51));
    push2(mk(OP_SUB, 52), mk(OP_SUB, 53));
    push1(mk(OP_SUB, 54));
    check("preflush.count", 64'(count), 64'd5);
    in_valid = 2'b11; in_inst0 = mk(OP_SUB, 55); in_inst1 = mk(OP_SUB, 56);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 2'b00;
    check("flush.count", 64'(count), 64'd0);
    check("flush.v", 64'({out_valid0, out_valid1}), 64'd0);
    check("flush.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check("postflush.v", 64'({out_valid0, out_valid1}), 64'd0);

    push2(mk(OP_ADD, 60), mk(OP_SUB, 61));
    step();
    check("prereset.v", 64'({out_valid0, out_valid1}), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    check("areset.v", 64'({out_valid0, out_valid1}), 64'd0);
    check("areset.inst0", 64'(out_inst0), 64'd0);
    check("areset.count", 64'(count), 64'd0);
    check("areset.in_ready", 64'(in_ready), 64'd1);
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
